// File: rtl/sr_imem_pkg.sv
// Shared types and constants for the sr_cpu instruction-memory boot loader.
package sr_imem_pkg;

   typedef enum logic [1:0] {
      LEN_LO = 2'd0,
      LEN_HI = 2'd1,
      LOAD   = 2'd2,
      RUN    = 2'd3
   } imem_ld_state_t;

   localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

endpackage

// File: rtl/sr_imem_ram.sv
// Word array with one synchronous write port and one asynchronous read port.
module sr_imem_ram #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0] mem [DEPTH];

   // Contents are deliberately not reset; the loader masks stale words.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sr_imem_loader.sv
// Instruction memory for sr_cpu: serial length-prefixed boot load, then
// zero-latency fetch with NOP substitution outside the loaded range.
//
// state  | meaning
// LEN_LO | waiting for LEN[7:0]
// LEN_HI | waiting for LEN[15:8]
// LOAD   | assembling little-endian payload words into memory
// RUN    | load finished, CPU released; terminal until rst
module sr_imem_loader
   import sr_imem_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic [31:0]       imAddr,
   output logic [31:0]       imData,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   word_count
);

   localparam int          DEPTH   = 2 ** ADDR_W;
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   imem_ld_state_t state_q, state_d;
   logic [7:0]     len_lo_q, len_lo_d;
   logic [15:0]    len_q, len_d;
   logic [15:0]    widx_q, widx_d;
   logic [1:0]     byte_cnt_q, byte_cnt_d;
   logic [23:0]    asm_q, asm_d;
   logic           load_err_q, load_err_d;

   logic              accept;
   logic [15:0]       len_hdr;
   logic              widx_in_range;
   logic              ram_we;
   logic [31:0]       ram_wdata;
   logic [ADDR_W-1:0] ram_waddr;
   logic [31:0]       ram_rdata;
   logic              fetch_in_range;

   assign accept        = in_valid && in_ready;
   assign len_hdr       = {in_data, len_lo_q};
   assign widx_in_range = ({1'b0, widx_q} < DEPTH_L);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LEN_LO;
         len_lo_q   <= '0;
         len_q      <= '0;
         widx_q     <= '0;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_lo_q   <= len_lo_d;
         len_q      <= len_d;
         widx_q     <= widx_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         load_err_q <= load_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_lo_d   = len_lo_q;
      len_d      = len_q;
      widx_d     = widx_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      load_err_d = load_err_q;
      ram_we     = 1'b0;
      ram_wdata  = {in_data, asm_q};
      ram_waddr  = widx_q[ADDR_W-1:0];

      case (state_q)
         LEN_LO: begin
            if (accept) begin
               len_lo_d = in_data;
               state_d  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_d      = len_hdr;
               widx_d     = '0;
               byte_cnt_d = '0;
               if ({1'b0, len_hdr} > DEPTH_L) load_err_d = 1'b1;
               state_d = (len_hdr == 16'd0) ? RUN : LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               if (byte_cnt_q == 2'd3) begin
                  // Words past the array end are consumed but never written.
                  ram_we     = widx_in_range && !rst;
                  widx_d     = widx_q + 16'd1;
                  byte_cnt_d = '0;
                  if ((widx_q + 16'd1) == len_q) state_d = RUN;
               end else begin
                  case (byte_cnt_q)
                     2'd0:    asm_d[7:0]   = in_data;
                     2'd1:    asm_d[15:8]  = in_data;
                     default: asm_d[23:16] = in_data;
                  endcase
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end
         default: ;
      endcase
   end

   sr_imem_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (imAddr[ADDR_W-1:0]),
      .rdata (ram_rdata)
   );

   assign in_ready   = (state_q != RUN);
   assign cpu_rst    = (state_q != RUN);
   assign load_done  = (state_q == RUN);
   assign load_err   = load_err_q;
   assign word_count = widx_in_range ? widx_q[ADDR_W:0] : (ADDR_W+1)'(DEPTH);

   // Full 32-bit compare so high address bits can never alias into the array.
   assign fetch_in_range = (imAddr < 32'(word_count));
   assign imData         = fetch_in_range ? ram_rdata : IMEM_NOP;

endmodule

// File: tb/tb_sr_imem_loader.sv
// Randomized directed bench for sr_imem_loader against a word-level reference model.
`timescale 1ns/1ps
module tb_sr_imem_loader;
   import sr_imem_pkg::*;

   localparam int AW_A = 6, DEPTH_A = 64;
   localparam int AW_B = 2, DEPTH_B = 4;

   logic clk = 1'b0;
   logic rst;

   logic            a_in_valid, a_in_ready, a_cpu_rst, a_load_done, a_load_err;
   logic [7:0]      a_in_data;
   logic [31:0]     a_imaddr, a_imdata;
   logic [AW_A:0]   a_wc;

   logic            b_in_valid, b_in_ready, b_cpu_rst, b_load_done, b_load_err;
   logic [7:0]      b_in_data;
   logic [31:0]     b_imaddr, b_imdata;
   logic [AW_B:0]   b_wc;

   sr_imem_loader #(.ADDR_W(AW_A)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
      .in_ready(a_in_ready), .imAddr(a_imaddr), .imData(a_imdata),
      .cpu_rst(a_cpu_rst), .load_done(a_load_done), .load_err(a_load_err),
      .word_count(a_wc)
   );

   sr_imem_loader #(.ADDR_W(AW_B)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
      .in_ready(b_in_ready), .imAddr(b_imaddr), .imData(b_imdata),
      .cpu_rst(b_cpu_rst), .load_done(b_load_done), .load_err(b_load_err),
      .word_count(b_wc)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] model_a [DEPTH_A];
   int          wc_a;
   logic [31:0] words_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_fetch_a(input logic [31:0] addr);
      if (addr < 32'(wc_a)) return model_a[addr[AW_A-1:0]];
      return IMEM_NOP;
   endfunction

   // All tasks start and end at posedge+1.
   task automatic send_a(input logic [7:0] b, input int gap, input logic exp_ready);
      repeat (gap) begin @(posedge clk); #1; end
      a_in_valid = 1'b1;
      a_in_data  = b;
      #1 check("a_in_ready", a_in_ready, exp_ready);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      b_in_valid = 1'b1;
      b_in_data  = b;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      @(posedge clk); #1;
      rst  = 1'b0;
      wc_a = 0;
   endtask

   task automatic fill_words(input int n);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
   endtask

   // Sends LEN plus words_q[0..len-1] into dut_a and updates the model.
   task automatic load_a(input int len, input int maxgap);
      logic [7:0] bytes [$];
      int total;
      bytes.push_back(len[7:0]);
      bytes.push_back(len[15:8]);
      for (int w = 0; w < len; w++)
         for (int k = 0; k < 4; k++) bytes.push_back(words_q[w][8*k +: 8]);
      total = bytes.size();
      for (int i = 0; i < total; i++) begin
         send_a(bytes[i], $urandom_range(maxgap, 0), 1'b1);
         check("a_cpu_rst_during_load", a_cpu_rst, (i != total - 1));
         if (i == 1) check("a_load_err_hdr", a_load_err, (len > DEPTH_A));
      end
      for (int w = 0; w < len && w < DEPTH_A; w++) model_a[w] = words_q[w];
      wc_a = (len > DEPTH_A) ? DEPTH_A : len;
   endtask

   task automatic verify_a(input string tag);
      logic [31:0] probe [$];
      check({tag, "_wc"}, 32'(a_wc), 32'(wc_a));
      check({tag, "_load_done"}, a_load_done, 1'b1);
      check({tag, "_cpu_rst"}, a_cpu_rst, 1'b0);
      check({tag, "_in_ready"}, a_in_ready, 1'b0);
      for (int i = 0; i <= DEPTH_A + 1; i++) probe.push_back(32'(i));
      probe.push_back(32'h0000_0100);
      probe.push_back(32'h8000_0001);
      probe.push_back(32'hFFFF_FFFF);
      foreach (probe[i]) begin
         a_imaddr = probe[i];
         #0.1 check({tag, "_fetch"}, a_imdata, exp_fetch_a(probe[i]));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_imaddr = '0;
      b_in_valid = 1'b0; b_in_data = '0; b_imaddr = '0;
      wc_a = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      check("rst_in_ready", a_in_ready, 1'b1);
      check("rst_cpu_rst", a_cpu_rst, 1'b1);
      check("rst_load_done", a_load_done, 1'b0);
      check("rst_load_err", a_load_err, 1'b0);
      check("rst_wc", 32'(a_wc), 32'd0);
      check("rst_fetch0", a_imdata, IMEM_NOP);

      // Normal load, back-to-back bytes
      words_q = '{32'h0010_0513, 32'h0020_0593};
      load_a(2, 0);
      check("normal_mem0", model_a[0], 32'h0010_0513);
      verify_a("normal");
      for (int i = 0; i < 3; i++) send_a(8'hFF, 0, 1'b0);
      verify_a("normal_extra");

      // Zero length
      do_reset();
      check("zero_pre_wc", 32'(a_wc), 32'd0);
      a_imaddr = 32'd0;
      #0.1 check("zero_pre_fetch_masked", a_imdata, IMEM_NOP);
      @(posedge clk); #1;
      words_q.delete();
      load_a(0, 0);
      verify_a("zero");

      // Throttled source: same frame with random gaps, then a random frame
      do_reset();
      words_q = '{32'h0010_0513, 32'h0020_0593};
      load_a(2, 5);
      verify_a("throttled");
      for (int i = 0; i < 2; i++) send_a($urandom_range(255, 0), $urandom_range(3, 0), 1'b0);
      verify_a("throttled_extra");
      do_reset();
      fill_words($urandom_range(10, 3));
      load_a(words_q.size(), 5);
      verify_a("random");

      // Exactly full array: no error
      do_reset();
      fill_words(DEPTH_A);
      load_a(DEPTH_A, 1);
      verify_a("full");
      check("full_load_err", a_load_err, 1'b0);

      // Reset mid-word, coinciding with a byte offer
      do_reset();
      fill_words(3);
      send_a(8'd3, 0, 1'b1);
      send_a(8'd0, 0, 1'b1);
      for (int k = 0; k < 4; k++) send_a(words_q[0][8*k +: 8], 0, 1'b1);
      model_a[0] = words_q[0];
      send_a(words_q[1][7:0], 0, 1'b1);
      send_a(words_q[1][15:8], 0, 1'b1);
      rst = 1'b1;
      a_in_valid = 1'b1;
      a_in_data  = 8'hAA;
      @(posedge clk); #1;
      rst = 1'b0;
      a_in_valid = 1'b0;
      wc_a = 0;
      check("midrst_in_ready", a_in_ready, 1'b1);
      check("midrst_cpu_rst", a_cpu_rst, 1'b1);
      check("midrst_load_done", a_load_done, 1'b0);
      check("midrst_wc", 32'(a_wc), 32'd0);
      a_imaddr = 32'd0;
      #0.1 check("midrst_fetch0", a_imdata, IMEM_NOP);
      @(posedge clk); #1;
      fill_words(3);
      load_a(3, 2);
      verify_a("reload");

      // Overflow on the 4-word instance
      do_reset();
      fill_words(6);
      send_b(8'd6);
      check("ovf_err_before_hi", b_load_err, 1'b0);
      send_b(8'd0);
      check("ovf_err_after_hi", b_load_err, 1'b1);
      for (int w = 0; w < 6; w++)
         for (int k = 0; k < 4; k++) begin
            send_b(words_q[w][8*k +: 8]);
            check("ovf_cpu_rst", b_cpu_rst, !(w == 5 && k == 3));
         end
      check("ovf_wc", 32'(b_wc), 32'd4);
      check("ovf_load_done", b_load_done, 1'b1);
      check("ovf_load_err", b_load_err, 1'b1);
      check("ovf_in_ready", b_in_ready, 1'b0);
      for (int i = 0; i < 8; i++) begin
         b_imaddr = 32'(i);
         #0.1 check("ovf_fetch", b_imdata, (i < DEPTH_B) ? words_q[i] : IMEM_NOP);
      end
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
